// File: rtl/flash_playback_ctrl_if.sv
// Avalon-style word read port between the playback controller and the flash.
interface flash_playback_ctrl_if #(
    parameter int unsigned ADDR_W = 23
);
    logic              flash_mem_read;
    logic [ADDR_W-1:0] flash_mem_address;
    logic              flash_mem_waitrequest;
    logic [31:0]       flash_mem_readdata;
    logic              flash_mem_readdatavalid;

    modport master (
        output flash_mem_read,
        output flash_mem_address,
        input  flash_mem_waitrequest,
        input  flash_mem_readdata,
        input  flash_mem_readdatavalid
    );

    modport slave (
        input  flash_mem_read,
        input  flash_mem_address,
        output flash_mem_waitrequest,
        output flash_mem_readdata,
        output flash_mem_readdatavalid
    );
endinterface

// File: rtl/flash_playback_ctrl.sv
// Audio transport controller: fetches 32-bit flash words and plays them as two
// 16-bit samples paced by sync_clk, with pause, direction, restart and wrap.
module flash_playback_ctrl #(
    parameter int unsigned       ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(23'h000000),
    parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(23'h7FFFF)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sync_clk,
    input  logic                         play,
    input  logic                         dir,
    input  logic                         restart,
    flash_playback_ctrl_if.master        flash,
    output logic [15:0]                  audio_data,
    output logic                         audio_valid,
    output logic                         busy
);
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned REQ_BIT  = 1;

    // One-hot so the read strobe can be taken straight from a single flop.
    typedef enum logic [5:0] {
        IDLE        = 6'b000001,
        REQ         = 6'b000010,
        WAIT_DATA   = 6'b000100,
        PLAY_FIRST  = 6'b001000,
        PLAY_SECOND = 6'b010000,
        ADVANCE     = 6'b100000
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_W-1:0]     addr, addr_nxt;
    logic [WORD_W-1:0]     word, word_nxt;
    logic                  order, order_nxt;
    logic                  pending, pending_nxt;
    logic [SAMPLE_W-1:0]   data_nxt;
    logic                  valid_nxt;
    logic                  busy_nxt;
    logic                  restart_req;
    logic [ADDR_W-1:0]     restart_addr;

    assign flash.flash_mem_read    = state[REQ_BIT];
    assign flash.flash_mem_address = addr;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            addr        <= START_ADDR;
            word        <= '0;
            order       <= 1'b0;
            pending     <= 1'b0;
            audio_data  <= '0;
            audio_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            addr        <= addr_nxt;
            word        <= word_nxt;
            order       <= order_nxt;
            pending     <= pending_nxt;
            audio_data  <= data_nxt;
            audio_valid <= valid_nxt;
            busy        <= busy_nxt;
        end
    end

    // Next-state, address, sample selection and restart servicing.
    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr;
        word_nxt     = word;
        order_nxt    = order;
        pending_nxt  = pending | restart;
        data_nxt     = audio_data;
        valid_nxt    = 1'b0;
        restart_req  = pending | restart;
        restart_addr = dir ? START_ADDR : END_ADDR;

        case (state)
            IDLE: begin
                if (restart_req) begin
                    addr_nxt    = restart_addr;
                    pending_nxt = 1'b0;
                end
                if (play) state_nxt = REQ;
            end
            REQ: begin
                if (!flash.flash_mem_waitrequest) state_nxt = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (flash.flash_mem_readdatavalid) begin
                    if (restart_req) begin
                        addr_nxt    = restart_addr;
                        pending_nxt = 1'b0;
                        state_nxt   = REQ;
                    end else begin
                        word_nxt  = flash.flash_mem_readdata;
                        order_nxt = dir;
                        state_nxt = PLAY_FIRST;
                    end
                end
            end
            PLAY_FIRST, PLAY_SECOND: begin
                if (restart_req) begin
                    addr_nxt    = restart_addr;
                    pending_nxt = 1'b0;
                    state_nxt   = REQ;
                end else if (sync_clk && play) begin
                    // order=1: low half first; order=0: high half first.
                    if ((state == PLAY_FIRST) == order) data_nxt = word[SAMPLE_W-1:0];
                    else                               data_nxt = word[WORD_W-1:SAMPLE_W];
                    valid_nxt = 1'b1;
                    state_nxt = (state == PLAY_FIRST) ? PLAY_SECOND : ADVANCE;
                end
            end
            ADVANCE: begin
                state_nxt = REQ;
                if (restart_req) begin
                    addr_nxt    = restart_addr;
                    pending_nxt = 1'b0;
                end else if (dir) begin
                    addr_nxt = (addr == END_ADDR) ? START_ADDR : addr + ADDR_W'(1);
                end else begin
                    addr_nxt = (addr == START_ADDR) ? END_ADDR : addr - ADDR_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end
endmodule

// File: doc/flash_playback_ctrl.md
Name: flash_playback_ctrl

Overview:
Sequences audio playback from the 32-bit-wide flash read port and replaces the single-direction read/play loop with a full transport controller. It issues Avalon-style word reads and splits each word into two 16-bit samples. Samples are released one per sync_clk strobe. It adds play/pause, forward/backward direction, restart and address wrap-around, and owns the word address, so no separate address counter is needed.

Parameters:
ADDR_W, 23, width of flash word address
START_ADDR, 23'h000000, first word of the audio clip
END_ADDR, 23'h7FFFF, last word of the audio clip (END_ADDR > START_ADDR)

Ports:
clk  in  1  system clock
reset  in  1  async active-low reset
sync_clk  in  1  sample-rate strobe, one clk cycle wide, already synchronised to clk
play  in  1  1 = run, 0 = pause (level)
dir  in  1  1 = forward, 0 = backward (level)
restart  in  1  one-cycle pulse; jump to clip start for the current direction
flash_mem_read  out  1  read request
flash_mem_address  out  ADDR_W  word address of the request
flash_mem_waitrequest  in  1  slave stall; request is held while high
flash_mem_readdata  in  32  returned word
flash_mem_readdatavalid  in  1  readdata valid strobe
audio_data  out  16  current sample (signed; passed through unmodified)
audio_valid  out  1  one-cycle pulse when audio_data updates
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset value of each output:
  - reset=0 (async) -> state IDLE, address=START_ADDR.
  - flash_mem_read=0, audio_data=0, audio_valid=0, busy=0.
  - Internal restart_pending=0, word register=0.
- Outputs are registered, with one exception: flash_mem_read is decoded from state (REQ) and is glitch-free because the state is one-hot or gray encoded.
- States:
  - IDLE: -> REQ when play=1.
  - REQ: flash_mem_read=1; the address is held stable. When waitrequest=0 the request is accepted -> WAIT_DATA.
  - WAIT_DATA: on readdatavalid, latch the word and latch the word order from dir -> PLAY_FIRST.
  - PLAY_FIRST: on sync_clk && play, emit the first sample -> PLAY_SECOND.
  - PLAY_SECOND: on sync_clk && play, emit the second sample -> ADVANCE.
  - ADVANCE: update the address (one cycle) -> REQ.
- Sample order:
  - dir=1 at latch: first sample = word[15:0], second = word[31:16].
  - dir=0 at latch: first = word[31:16], second = word[15:0].
- Emission: audio_data updates and audio_valid pulses on the clk edge after the accepted sync_clk cycle (1-cycle latency).
- Pause: play=0 in PLAY_FIRST or PLAY_SECOND ignores sync_clk; audio_data holds its last value and audio_valid stays 0. A read already in REQ or WAIT_DATA still completes. Pausing never returns the block to IDLE.
- Address advance in ADVANCE, with dir sampled at ADVANCE:
  - Forward: address+1; END_ADDR wraps to START_ADDR.
  - Backward: address-1; START_ADDR wraps to END_ADDR.
  - No other arithmetic: the address never leaves [START_ADDR, END_ADDR].
- Restart: the restart pulse sets restart_pending. The pending restart is serviced at the first cycle the state is one of:
  - IDLE, PLAY_FIRST, PLAY_SECOND or ADVANCE: load address = START_ADDR if dir=1, else END_ADDR. Clear restart_pending. -> REQ (IDLE -> REQ only if play=1; otherwise the address is loaded and the block stays in IDLE).
  - REQ or WAIT_DATA: the outstanding read finishes. In WAIT_DATA the returned word is discarded (nothing is emitted), then the address is reloaded -> REQ.
- Simultaneous events:
  - restart and sync_clk in the same cycle in a PLAY state: restart wins and no sample is emitted.
  - restart during reset: ignored.
  - readdatavalid while not in WAIT_DATA: ignored.
- Reset mid-read: the state returns to IDLE immediately. A later stray readdatavalid is ignored in IDLE.
- Direction change mid-word: the current word keeps its latched order; the new dir takes effect at ADVANCE.

Test Plan:
- Forward run: reset release, play=1, dir=1, slave returns 32'hBBBB_AAAA for addr 0 with waitrequest=0.
  - Required: flash_mem_read high 1 cycle at address 0.
  - Two sync_clk pulses -> audio_data 16'hAAAA then 16'hBBBB, each with a 1-cycle audio_valid.
  - Next request at address 1.
- Backward plus wrap: dir=0 from reset after a restart, so the address is END_ADDR=23'h7FFFF.
  - Word 32'h1234_5678 -> emits 16'h1234 then 16'h5678.
  - Next address 23'h7FFFE. Repeat from START_ADDR -> next address 23'h7FFFF.
- Waitrequest stall: hold waitrequest=1 for 5 cycles in REQ.
  - Required: flash_mem_read stays 1 and the address stays constant for 6 cycles.
  - Exactly one read is accepted.
- Pause: deassert play in PLAY_SECOND and send 4 sync_clk pulses.
  - Required: no audio_valid and audio_data unchanged.
  - Re-assert play, then 1 sync_clk -> second sample emitted.
- Restart during WAIT_DATA at address 10 with dir=1.
  - Required: the returned word is not emitted (no audio_valid).
  - Next flash_mem_read at address 0.
- Async reset asserted in WAIT_DATA.
  - Required: outputs zero immediately and busy=0.
  - A readdatavalid pulse 2 cycles later produces no audio_valid.
  - After release with play=1, the first read is at address 0.
